// File: rtl/pc_gen_if.sv
// rtl/pc_gen_if.sv - decode/control to fetch-PC generator signal bundle
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             stall_i;
  logic             exc_req_i;
  logic [2:0]       npc_sel_i;
  logic [15:0]      offset_i;
  logic [25:0]      irrelative_i;
  logic [WIDTH-1:0] register_i;
  logic             link_i;
  logic [WIDTH-1:0] pc_o;
  logic [WIDTH-1:0] pc_plus4_o;
  logic [WIDTH-1:0] npc_o;
  logic             ras_empty_o;
  logic             addr_err_o;

  // Decode/control side: drives selects and targets, observes the PC.
  modport master (
    output stall_i, exc_req_i, npc_sel_i, offset_i, irrelative_i, register_i, link_i,
    input  pc_o, pc_plus4_o, npc_o, ras_empty_o, addr_err_o
  );

  // PC generator side.
  modport slave (
    input  stall_i, exc_req_i, npc_sel_i, offset_i, irrelative_i, register_i, link_i,
    output pc_o, pc_plus4_o, npc_o, ras_empty_o, addr_err_o
  );
endinterface

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with circular return-address stack
module pc_gen #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
  parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
  parameter int               RAS_DEPTH = 4
) (
  input logic       clk,
  input logic       rst,
  pc_gen_if.slave   bus
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(RAS_DEPTH);

  localparam logic [2:0] SEL_REL = 3'd1;
  localparam logic [2:0] SEL_IRR = 3'd2;
  localparam logic [2:0] SEL_REG = 3'd3;
  localparam logic [2:0] SEL_RET = 3'd4;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             addr_err_q, addr_err_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] rel_tgt;
  logic [WIDTH-1:0] irr_tgt;
  logic [WIDTH-1:0] raw_tgt;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] npc;
  logic             is_indirect;
  logic             ras_empty;
  logic             advance;
  logic             push;
  logic             pop;
  logic [PW-1:0]    wr_idx;

  // Target selection, priority resolution and RAS pointer next-state.
  always_comb begin
    pc_plus4    = pc_q + WIDTH'(4);
    rel_tgt     = pc_plus4 + {{(WIDTH-18){bus.offset_i[15]}}, bus.offset_i, 2'b00};
    irr_tgt     = {pc_q[WIDTH-1:28], bus.irrelative_i, 2'b00};
    ras_empty   = (cnt_q == '0);
    raw_tgt     = bus.register_i;
    target      = pc_plus4;
    is_indirect = 1'b0;

    case (bus.npc_sel_i)
      SEL_REL: target = rel_tgt;
      SEL_IRR: target = irr_tgt;
      SEL_REG: is_indirect = 1'b1;
      SEL_RET: begin
        is_indirect = 1'b1;
        // An empty stack falls back to the register operand without popping.
        if (!ras_empty) raw_tgt = ras_q[top_q];
      end
      default: target = pc_plus4;
    endcase

    if (is_indirect) target = {raw_tgt[WIDTH-1:2], 2'b00};

    advance = !bus.exc_req_i && !bus.stall_i;
    push    = advance && bus.link_i;
    pop     = advance && (bus.npc_sel_i == SEL_RET) && !ras_empty;

    if (bus.exc_req_i)    npc = EXC_VEC;
    else if (bus.stall_i) npc = pc_q;
    else                  npc = target;
    pc_d = npc;

    if (bus.exc_req_i)    addr_err_d = 1'b0;
    else if (bus.stall_i) addr_err_d = addr_err_q;
    else                  addr_err_d = is_indirect && (raw_tgt[1:0] != 2'b00);

    // Call+return on the same edge replaces the top in place.
    top_d  = top_q;
    cnt_d  = cnt_q;
    wr_idx = top_q + PW'(1);
    if (push && pop) begin
      wr_idx = top_q;
    end else if (push) begin
      top_d = top_q + PW'(1);
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
    end else if (pop) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  // PC, error flag and stack pointers; reset may arrive at any time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      addr_err_q <= 1'b0;
      top_q      <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      addr_err_q <= addr_err_d;
      top_q      <= top_d;
      cnt_q      <= cnt_d;
    end
  end

  // Stack contents carry no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (push) ras_q[wr_idx] <= pc_plus4;
  end

  assign bus.pc_o        = pc_q;
  assign bus.pc_plus4_o  = pc_plus4;
  assign bus.npc_o       = npc;
  assign bus.ras_empty_o = ras_empty;
  assign bus.addr_err_o  = addr_err_q;
endmodule
